// File: rtl/cia_serial.sv
// CIA serial data port: SDR register, 8-bit shift register and CNT/SP pin logic.
// Build option CIA_SP_SYNC_EN adds a two-flop synchronizer on the CNT and SP pins.
module cia_serial (
  input  logic       clk,
  input  logic       res,
  input  logic       phi2_dn,
  input  logic       rd,
  input  logic       we,
  input  logic [3:0] addr,
  input  logic [7:0] data,
  input  logic       spmode,
  input  logic       ta_underflow,
  input  logic       cnt_in,
  input  logic       sp_in,
  output logic [7:0] regs,
  output logic       cnt_out,
  output logic       sp_out,
  output logic       sp_int
);

  // state | meaning
  // IDLE  | output mode waiting for a pending SDR byte (also parked here in input mode)
  // SHIFT | output mode clocking a byte out on timer A underflows
  typedef enum logic {IDLE, SHIFT} state_t;

  state_t     state;
  logic [7:0] sdr;
  logic [7:0] shift;
  logic [2:0] bitcnt;
  logic       pending;
  logic       cnt_prev;
  logic       mode_prev;
  logic       cnt_s;
  logic       sp_s;
  logic       wr_sdr;
  logic       cnt_rise;
  logic       mode_chg;
  logic       last_bit;
  logic [7:0] shift_in;
  logic       rd_unused;

  assign regs      = sdr;
  assign wr_sdr    = we && (addr == 4'hC) && phi2_dn;
  assign cnt_rise  = cnt_s && !cnt_prev;
  assign mode_chg  = spmode != mode_prev;
  assign last_bit  = bitcnt == 3'd7;
  assign shift_in  = {shift[6:0], sp_s};
  assign rd_unused = rd;

`ifdef CIA_SP_SYNC_EN
  logic [1:0] cnt_sync;
  logic [1:0] sp_sync;

  always_ff @(posedge clk) begin
    if (res) begin
      cnt_sync <= 2'b11;
      sp_sync  <= 2'b11;
    end else begin
      cnt_sync <= {cnt_sync[0], cnt_in};
      sp_sync  <= {sp_sync[0], sp_in};
    end
  end

  assign cnt_s = cnt_sync[1];
  assign sp_s  = sp_sync[1];
`else
  assign cnt_s = cnt_in;
  assign sp_s  = sp_in;
`endif

  always_ff @(posedge clk) begin
    if (res) begin
      state     <= IDLE;
      sdr       <= 8'h00;
      shift     <= 8'h00;
      bitcnt    <= 3'd0;
      pending   <= 1'b0;
      cnt_out   <= 1'b1;
      sp_out    <= 1'b1;
      sp_int    <= 1'b0;
      cnt_prev  <= 1'b1;
      mode_prev <= 1'b0;  // CRA resets to input mode
    end else if (phi2_dn) begin
      mode_prev <= spmode;
      cnt_prev  <= cnt_s;
      sp_int    <= 1'b0;
      if (mode_chg) begin
        state    <= IDLE;
        bitcnt   <= 3'd0;
        pending  <= 1'b0;
        cnt_out  <= 1'b1;
        cnt_prev <= 1'b1;
        if (!spmode) sp_out <= 1'b1;
        if (wr_sdr) sdr <= data;
      end else if (spmode) begin
        if (wr_sdr) begin
          sdr     <= data;
          pending <= 1'b1;
        end
        case (state)
          IDLE: begin
            if (pending) begin
              shift  <= sdr;
              sp_out <= sdr[7];
              bitcnt <= 3'd0;
              state  <= SHIFT;
              if (!wr_sdr) pending <= 1'b0;
            end
          end
          SHIFT: begin
            if (ta_underflow) begin
              cnt_out <= !cnt_out;
              if (cnt_out) begin
                sp_out <= shift[7];
              end else begin
                shift  <= shift << 1;
                bitcnt <= bitcnt + 3'd1;
                if (last_bit) begin
                  sp_int <= 1'b1;
                  // a byte already queued follows without an idle CNT period
                  if (pending) begin
                    shift  <= sdr;
                    sp_out <= sdr[7];
                    if (!wr_sdr) pending <= 1'b0;
                  end else begin
                    state <= IDLE;
                  end
                end
              end
            end
          end
          default: state <= IDLE;
        endcase
      end else begin
        cnt_out <= 1'b1;
        sp_out  <= 1'b1;
        if (wr_sdr) sdr <= data;
        if (cnt_rise) begin
          shift  <= shift_in;
          bitcnt <= bitcnt + 3'd1;
          if (last_bit) begin
            sdr    <= shift_in;
            sp_int <= 1'b1;
          end
        end
      end
    end
  end

endmodule
